// File: rtl/system_cpu_cpu_debug_pkg.sv
// Shared definitions for the OCI debug-memory responder.
// Holds jdo field positions and the FSM and command-kind encodings.
package system_cpu_cpu_debug_pkg;

  localparam int JDO_W     = 38;
  localparam int ADDR_LSB  = 26;
  localparam int RD_FLAG   = 35;
  localparam int WDATA_LSB = 3;

  typedef enum logic [2:0] {
    IDLE,
    JRD,
    JCAP,
    JWR,
    AVACK
  } state_e;

  typedef enum logic [1:0] {
    NONE,
    RD,
    WR
  } kind_e;

endpackage

// File: rtl/system_cpu_cpu_debug_ocimem_ram.sv
// Single-port debug RAM, 32-bit words, byte enables,
// one-cycle registered read (read-before-write).
module system_cpu_cpu_debug_ocimem_ram #(
  parameter int ADDR_W = 8,
  parameter     INIT_FILE = ""
) (
  input  logic              clk,
  input  logic [ADDR_W-1:0] addr,
  input  logic              we,
  input  logic [3:0]        be,
  input  logic [31:0]       wdata,
  output logic [31:0]       q
);

  logic [31:0] mem [2**ADDR_W];

  always_ff @(posedge clk) begin
    for (int i = 0; i < 4; i++) begin
      if (we && be[i]) mem[addr][8*i +: 8] <= wdata[8*i +: 8];
    end
    q <= mem[addr];
  end

endmodule

// File: rtl/system_cpu_cpu_debug_ocimem_responder.sv
// Sysclk-side OCI memory responder: serves JTAG debug commands
// and a CPU Avalon slave against one private debug RAM.
module system_cpu_cpu_debug_ocimem_responder
  import system_cpu_cpu_debug_pkg::*;
#(
  parameter int ADDR_W = 8,
  parameter     INIT_FILE = ""
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic [JDO_W-1:0]  jdo,
  input  logic              take_action_ocimem_a,
  input  logic              take_action_ocimem_b,
  input  logic              take_no_action_ocimem_a,
  input  logic [ADDR_W-1:0] address,
  input  logic              chipselect,
  input  logic              read,
  input  logic              write,
  input  logic [31:0]       writedata,
  input  logic [3:0]        byteenable,
  input  logic              debugaccess,
  output logic [31:0]       readdata,
  output logic              waitrequest,
  output logic [31:0]       MonDReg,
  output logic              mon_valid,
  output logic              cmd_overrun
);

  state_e state, state_nx;

  logic [ADDR_W-1:0] jaddr, jaddr_nx;
  logic [31:0]       wdata;
  logic [31:0]       rd_hold;

  logic              pend_v;
  kind_e             pend_kind;
  logic              pend_ld;
  logic [ADDR_W-1:0] pend_addr;
  logic [31:0]       pend_data;

  kind_e             stb_kind;
  logic              stb_ld;
  logic              any_stb;
  logic              consume;
  logic              av_req;
  logic              av_ack;

  logic [ADDR_W-1:0] ram_addr;
  logic              ram_we;
  logic [3:0]        ram_be;
  logic [31:0]       ram_wdata;
  logic [31:0]       ram_q;

  logic              unused;

  assign unused  = ^{jdo[37:36], jdo[2:0]};
  assign any_stb = take_action_ocimem_a | take_action_ocimem_b |
                   take_no_action_ocimem_a;
  assign consume = (state == IDLE) & pend_v;
  assign av_req  = chipselect & (read | write);
  assign av_ack  = (state == AVACK);

  assign waitrequest = av_req & ~av_ack;
  assign readdata    = av_ack ? ram_q : rd_hold;

  // Simultaneous strobes resolve a > b > no_action.
  always_comb begin
    stb_kind = NONE;
    stb_ld   = 1'b0;
    if (take_action_ocimem_a) begin
      stb_kind = jdo[RD_FLAG] ? RD : NONE;
      stb_ld   = 1'b1;
    end else if (take_action_ocimem_b) begin
      stb_kind = WR;
    end else if (take_no_action_ocimem_a) begin
      stb_kind = RD;
    end
  end

  // One-deep command slot; a newer strobe replaces an unserved one.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      pend_v      <= 1'b0;
      pend_kind   <= NONE;
      pend_ld     <= 1'b0;
      pend_addr   <= '0;
      pend_data   <= '0;
      cmd_overrun <= 1'b0;
    end else if (any_stb) begin
      pend_v    <= 1'b1;
      pend_kind <= stb_kind;
      pend_ld   <= stb_ld;
      pend_addr <= jdo[ADDR_LSB +: ADDR_W];
      pend_data <= jdo[WDATA_LSB +: 32];
      if (pend_v && !consume) cmd_overrun <= 1'b1;
    end else if (consume) begin
      pend_v <= 1'b0;
    end
  end

  always_comb begin
    state_nx  = state;
    jaddr_nx  = jaddr;
    ram_addr  = jaddr;
    ram_we    = 1'b0;
    ram_be    = 4'hF;
    ram_wdata = wdata;
    unique case (state)
      IDLE: begin
        if (pend_v) begin
          unique case (pend_kind)
            RD: begin
              jaddr_nx = pend_ld ? pend_addr : jaddr + 1'b1;
              state_nx = JRD;
            end
            WR: state_nx = JWR;
            default: jaddr_nx = pend_addr;
          endcase
        end else if (av_req && !any_stb) begin
          ram_addr  = address;
          ram_we    = write & debugaccess;
          ram_be    = byteenable;
          ram_wdata = writedata;
          state_nx  = AVACK;
        end
      end
      JRD:   state_nx = JCAP;
      JCAP:  state_nx = IDLE;
      JWR: begin
        ram_we   = 1'b1;
        jaddr_nx = jaddr + 1'b1;
        state_nx = IDLE;
      end
      AVACK: state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state     <= IDLE;
      jaddr     <= '0;
      wdata     <= '0;
      MonDReg   <= '0;
      mon_valid <= 1'b0;
      rd_hold   <= '0;
    end else begin
      state     <= state_nx;
      jaddr     <= jaddr_nx;
      mon_valid <= (state == JCAP);
      if (consume)         wdata   <= pend_data;
      if (state == JCAP)   MonDReg <= ram_q;
      if (av_ack)          rd_hold <= ram_q;
    end
  end

  system_cpu_cpu_debug_ocimem_ram #(
    .ADDR_W    (ADDR_W),
    .INIT_FILE (INIT_FILE)
  ) u_ram (
    .clk   (clk),
    .addr  (ram_addr),
    .we    (ram_we),
    .be    (ram_be),
    .wdata (ram_wdata),
    .q     (ram_q)
  );

endmodule

// File: tb/tb_system_cpu_cpu_debug_ocimem_responder.sv
// Directed bench for the OCI memory responder: JTAG read/write,
// address wrap, Avalon byte/debug qualifiers, contention, overrun, reset.
module tb_system_cpu_cpu_debug_ocimem_responder;

  logic        clk = 1'b0;
  logic        reset_n = 1'b0;
  logic [37:0] jdo = '0;
  logic        take_action_ocimem_a = 1'b0;
  logic        take_action_ocimem_b = 1'b0;
  logic        take_no_action_ocimem_a = 1'b0;
  logic [7:0]  address = '0;
  logic        chipselect = 1'b0;
  logic        read = 1'b0;
  logic        write = 1'b0;
  logic [31:0] writedata = '0;
  logic [3:0]  byteenable = '0;
  logic        debugaccess = 1'b0;
  logic [31:0] readdata;
  logic        waitrequest;
  logic [31:0] MonDReg;
  logic        mon_valid;
  logic        cmd_overrun;

  int errs = 0;
  int checks = 0;

  int          mon_n, mon_k0, mon_k1, av_k;
  logic [31:0] mon_d0, mon_d1, av_d;
  logic        wr_hi0;

  always #5 clk = ~clk;

  system_cpu_cpu_debug_ocimem_responder #(
    .ADDR_W    (8),
    .INIT_FILE ("")
  ) dut (
    .clk                     (clk),
    .reset_n                 (reset_n),
    .jdo                     (jdo),
    .take_action_ocimem_a    (take_action_ocimem_a),
    .take_action_ocimem_b    (take_action_ocimem_b),
    .take_no_action_ocimem_a (take_no_action_ocimem_a),
    .address                 (address),
    .chipselect              (chipselect),
    .read                    (read),
    .write                   (write),
    .writedata               (writedata),
    .byteenable              (byteenable),
    .debugaccess             (debugaccess),
    .readdata                (readdata),
    .waitrequest             (waitrequest),
    .MonDReg                 (MonDReg),
    .mon_valid               (mon_valid),
    .cmd_overrun             (cmd_overrun)
  );

  task automatic chk(input string tag, input logic [31:0] got,
                     input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errs++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  function automatic logic [37:0] mk_a(input logic [7:0] a,
                                       input logic rd);
    logic [37:0] v;
    v = '0;
    v[33:26] = a;
    v[35] = rd;
    return v;
  endfunction

  function automatic logic [37:0] mk_b(input logic [31:0] d);
    logic [37:0] v;
    v = '0;
    v[34:3] = d;
    return v;
  endfunction

  // k counts edges after the call; records mon pulses and Avalon completion
  task automatic poll(input int n);
    mon_n = 0; mon_k0 = 0; mon_k1 = 0; av_k = 0;
    mon_d0 = '0; mon_d1 = '0; av_d = '0;
    for (int k = 1; k <= n; k++) begin
      @(posedge clk); #1;
      if (mon_valid) begin
        if (mon_n == 0) begin mon_k0 = k; mon_d0 = MonDReg; end
        else begin mon_k1 = k; mon_d1 = MonDReg; end
        mon_n++;
      end
      if (chipselect && !waitrequest && av_k == 0) begin
        av_k = k;
        av_d = readdata;
        chipselect = 1'b0; read = 1'b0; write = 1'b0;
      end
    end
  endtask

  task automatic jcmd(input int which, input logic [37:0] v);
    @(posedge clk); #1;
    jdo = v;
    take_action_ocimem_a    = (which == 0);
    take_action_ocimem_b    = (which == 1);
    take_no_action_ocimem_a = (which == 2);
    @(posedge clk); #1;
    take_action_ocimem_a    = 1'b0;
    take_action_ocimem_b    = 1'b0;
    take_no_action_ocimem_a = 1'b0;
  endtask

  task automatic jread(input string tag, input logic [31:0] exp);
    poll(6);
    chk({tag, "_n"}, mon_n, 1);
    chk({tag, "_lat"}, mon_k0, 3);
    chk({tag, "_d"}, mon_d0, exp);
  endtask

  task automatic av_xfer(input logic wr, input logic [7:0] a,
                         input logic [31:0] d, input logic [3:0] be,
                         input logic dbg);
    @(posedge clk); #1;
    chipselect = 1'b1; read = !wr; write = wr;
    address = a; writedata = d; byteenable = be; debugaccess = dbg;
    #1;
    wr_hi0 = waitrequest;
    poll(6);
  endtask

  initial begin
    repeat (3) @(posedge clk);
    #1;
    chk("rst_mon", MonDReg, 0);
    chk("rst_mv", 32'(mon_valid), 0);
    chk("rst_ovr", 32'(cmd_overrun), 0);
    chk("rst_rd", readdata, 0);
    chk("rst_wait", 32'(waitrequest), 0);
    reset_n = 1'b1;

    jcmd(0, mk_a(8'h10, 1'b0)); poll(3);
    jcmd(1, mk_b(32'hDEADBEEF)); poll(3);
    jcmd(1, mk_b(32'h12345678)); poll(3);
    jcmd(0, mk_a(8'h10, 1'b1)); jread("rd10", 32'hDEADBEEF);
    jcmd(2, '0); jread("nxt11", 32'h12345678);

    jcmd(0, mk_a(8'h01, 1'b0)); poll(3);
    jcmd(1, mk_b(32'h11111111)); poll(3);
    jcmd(0, mk_a(8'hFF, 1'b0)); poll(3);
    jcmd(1, mk_b(32'hA5A5A5A5)); poll(3);
    jcmd(2, '0); jread("wrap01", 32'h11111111);
    jcmd(0, mk_a(8'hFF, 1'b1)); jread("rdFF", 32'hA5A5A5A5);

    av_xfer(1'b1, 8'h05, 32'h11223344, 4'hF, 1'b1);
    chk("av_w_wait0", 32'(wr_hi0), 1);
    chk("av_w_cyc", av_k, 1);
    av_xfer(1'b1, 8'h05, 32'hCAFEF00D, 4'b0011, 1'b1);
    chk("av_be_cyc", av_k, 1);
    av_xfer(1'b0, 8'h05, '0, 4'hF, 1'b1);
    chk("av_be_rd", av_d, 32'h1122F00D);
    av_xfer(1'b1, 8'h05, 32'hFFFFFFFF, 4'hF, 1'b0);
    chk("av_nodbg_cyc", av_k, 1);
    av_xfer(1'b1, 8'h05, 32'h00000000, 4'h0, 1'b1);
    chk("av_be0_cyc", av_k, 1);
    av_xfer(1'b0, 8'h05, '0, 4'hF, 1'b0);
    chk("av_nodbg_rd", av_d, 32'h1122F00D);
    av_xfer(1'b0, 8'hFF, '0, 4'hF, 1'b0);
    chk("av_rdFF", av_d, 32'hA5A5A5A5);

    // Avalon read and a JTAG read strobe land on the same edge
    @(posedge clk); #1;
    chipselect = 1'b1; read = 1'b1; address = 8'h05; debugaccess = 1'b1;
    jdo = mk_a(8'h10, 1'b1); take_action_ocimem_a = 1'b1;
    #1;
    chk("ct_wait0", 32'(waitrequest), 1);
    @(posedge clk); #1;
    take_action_ocimem_a = 1'b0;
    poll(8);
    chk("ct_mon_n", mon_n, 1);
    chk("ct_mon_lat", mon_k0, 3);
    chk("ct_mon_d", mon_d0, 32'hDEADBEEF);
    chk("ct_av_lat", av_k, 4);
    chk("ct_av_d", av_d, 32'h1122F00D);

    chk("ovr_pre", 32'(cmd_overrun), 0);
    @(posedge clk); #1;
    chipselect = 1'b1; read = 1'b1; address = 8'hFF;
    jdo = mk_a(8'h10, 1'b1); take_action_ocimem_a = 1'b1;
    @(posedge clk); #1;
    jdo = mk_a(8'h01, 1'b1);
    @(posedge clk); #1;
    jdo = mk_a(8'hFF, 1'b1);
    @(posedge clk); #1;
    take_action_ocimem_a = 1'b0;
    poll(10);
    chk("ovr_mon_n", mon_n, 2);
    chk("ovr_mon0", mon_d0, 32'hDEADBEEF);
    chk("ovr_k0", mon_k0, 1);
    chk("ovr_mon1", mon_d1, 32'hA5A5A5A5);
    chk("ovr_k1", mon_k1, 4);
    chk("ovr_av_k", av_k, 5);
    chk("ovr_av_d", av_d, 32'hA5A5A5A5);
    chk("ovr_flag", 32'(cmd_overrun), 1);
    poll(3);
    chk("ovr_sticky", 32'(cmd_overrun), 1);

    // reset lands while the read is in its capture cycle
    jcmd(0, mk_a(8'h10, 1'b1));
    @(posedge clk);
    @(posedge clk); #1;
    reset_n = 1'b0;
    #1;
    chk("rj_mon", MonDReg, 0);
    chk("rj_mv", 32'(mon_valid), 0);
    chk("rj_ovr", 32'(cmd_overrun), 0);
    chk("rj_rd", readdata, 0);
    @(posedge clk); #1;
    reset_n = 1'b1;
    poll(4);
    chk("rj_nomon", mon_n, 0);
    jcmd(0, mk_a(8'h10, 1'b1)); jread("rj_rd10", 32'hDEADBEEF);

    $display("Result: errors=%0d of %0d checks", errs, checks);
    $finish;
  end

endmodule
